dm_arb: RTL and testbench

- Two-port arbiter and sequencer in front of the single-port SISC data memory (16-bit word address, 32-bit data).
- Port 0 is the processor load/store path; port 1 is a secondary master (DMA/IO loader).
- Grants one transaction at a time with round-robin fairness, drives the memory address/data/write-enable, captures read data and returns it with a one-cycle ack.
- Supports a lock so one master can perform atomic back-to-back transactions (read-modify-write), with a lock timeout.

---
 rtl/dm_arb_pkg.sv | 14 +
 rtl/dm_arb_if.sv | 28 ++
 rtl/dm_arb_rr_pick2.sv | 27 ++
 rtl/dm_arb.sv | 128 ++++++++++++
 tb/tb_dm_arb.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/dm_arb_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
package dm_arb_pkg;
    localparam int DEF_AW = 16;
    localparam int DEF_DW = 32;

    localparam logic P0 = 1'b0;
    localparam logic P1 = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;
endpackage

// File: rtl/dm_arb_if.sv
// Requester ports plus the memory-side bus of the data-memory arbiter.
interface dm_arb_if
    import dm_arb_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
);
    logic          req0, req1, we0, we1, lock0, lock1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          ack0, ack1;
    logic [DW-1:0] rdata;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic          dm_we;
    logic [DW-1:0] dm_rdata;
    logic [1:0]    owner;

    modport slave (
        input  req0, req1, we0, we1, lock0, lock1, addr0, addr1, wdata0, wdata1, dm_rdata,
        output ack0, ack1, rdata, dm_addr, dm_wdata, dm_we, owner
    );

    modport master (
        output req0, req1, we0, we1, lock0, lock1, addr0, addr1, wdata0, wdata1, dm_rdata,
        input  ack0, ack1, rdata, dm_addr, dm_wdata, dm_we, owner
    );
endinterface

// File: rtl/dm_arb_rr_pick2.sv
// Combinational two-way round-robin pick; a held lock restricts the pick to its owner.
module rr_pick2
    import dm_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic ptr,
    input  logic lock_vld,
    input  logic lock_own,
    output logic win,
    output logic vld
);
    always_comb begin
        win = ptr;
        vld = 1'b0;
        if (lock_vld) begin
            win = lock_own;
            vld = lock_own ? req1 : req0;
        end else begin
            vld = req0 | req1;
            if (req0 && !req1)
                win = P0;
            else if (req1 && !req0)
                win = P1;
        end
    end
endmodule

// File: rtl/dm_arb.sv
// Two-port arbiter/sequencer for the single-port data memory: IDLE -> ACCESS -> RESP,
// round-robin between ports, optional lock with an idle timeout.
module dm_arb
    import dm_arb_pkg::*;
#(
    parameter int AW       = DEF_AW,
    parameter int DW       = DEF_DW,
    parameter int LOCK_TMO = 15
) (
    input logic     clk,
    input logic     rst_f,
    dm_arb_if.slave bus
);
    localparam logic [7:0] TMO_LAST = 8'(LOCK_TMO - 1);

    state_e        state_q, state_d;
    logic          win_q, win_d;
    logic          ptr_q, ptr_d;
    logic          lock_q, lock_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [1:0]    ack_q, ack_d;
    logic [1:0]    owner_q, owner_d;
    logic [AW-1:0] dm_addr_q, dm_addr_d;
    logic [DW-1:0] dm_wdata_q, dm_wdata_d;
    logic          dm_we_q, dm_we_d;
    logic [DW-1:0] rdata_q, rdata_d;

    logic pick_win, pick_vld;

    rr_pick2 u_pick (
        .req0     (bus.req0),
        .req1     (bus.req1),
        .ptr      (ptr_q),
        .lock_vld (lock_q),
        .lock_own (win_q),
        .win      (pick_win),
        .vld      (pick_vld)
    );

    always_comb begin
        state_d    = state_q;
        win_d      = win_q;
        ptr_d      = ptr_q;
        lock_d     = lock_q;
        cnt_d      = cnt_q;
        ack_d      = 2'b00;
        owner_d    = owner_q;
        dm_addr_d  = dm_addr_q;
        dm_wdata_d = dm_wdata_q;
        dm_we_d    = dm_we_q;
        rdata_d    = rdata_q;
        case (state_q)
            IDLE: begin
                // An owner request wins even on the expiry cycle, so it is tested first.
                if (pick_vld) begin
                    state_d    = ACCESS;
                    win_d      = pick_win;
                    cnt_d      = 8'd0;
                    owner_d    = pick_win ? 2'b10 : 2'b01;
                    dm_addr_d  = pick_win ? bus.addr1  : bus.addr0;
                    dm_wdata_d = pick_win ? bus.wdata1 : bus.wdata0;
                    dm_we_d    = pick_win ? bus.we1    : bus.we0;
                    lock_d     = pick_win ? bus.lock1  : bus.lock0;
                end else if (lock_q) begin
                    if (cnt_q == TMO_LAST) begin
                        lock_d  = 1'b0;
                        owner_d = 2'b00;
                        ptr_d   = ~win_q;
                        cnt_d   = 8'd0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            ACCESS: begin
                state_d     = RESP;
                dm_we_d     = 1'b0;
                ack_d[win_q] = 1'b1;
                if (!dm_we_q)
                    rdata_d = bus.dm_rdata;
            end
            RESP: begin
                state_d = IDLE;
                if (!lock_q) begin
                    ptr_d   = ~win_q;
                    owner_d = 2'b00;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            state_q    <= IDLE;
            win_q      <= P0;
            ptr_q      <= P0;
            lock_q     <= 1'b0;
            cnt_q      <= 8'd0;
            ack_q      <= 2'b00;
            owner_q    <= 2'b00;
            dm_addr_q  <= '0;
            dm_wdata_q <= '0;
            dm_we_q    <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            win_q      <= win_d;
            ptr_q      <= ptr_d;
            lock_q     <= lock_d;
            cnt_q      <= cnt_d;
            ack_q      <= ack_d;
            owner_q    <= owner_d;
            dm_addr_q  <= dm_addr_d;
            dm_wdata_q <= dm_wdata_d;
            dm_we_q    <= dm_we_d;
            rdata_q    <= rdata_d;
        end
    end

    assign bus.ack0     = ack_q[0];
    assign bus.ack1     = ack_q[1];
    assign bus.owner    = owner_q;
    assign bus.dm_addr  = dm_addr_q;
    assign bus.dm_wdata = dm_wdata_q;
    assign bus.dm_we    = dm_we_q;
    assign bus.rdata    = rdata_q;
endmodule

// File: tb/tb_dm_arb.sv
// Directed bench for dm_arb with a behavioural 256-word memory on the dm_* bus.
module tb_dm_arb;
    logic clk = 1'b0;
    logic rst_f = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    dm_arb_if #(.AW(16), .DW(32)) bus ();

    dm_arb #(.AW(16), .DW(32), .LOCK_TMO(15)) dut (
        .clk   (clk),
        .rst_f (rst_f),
        .bus   (bus)
    );

    logic [31:0] mem [256] = '{default: '0};
    always @(posedge clk) if (bus.dm_we) mem[bus.dm_addr[7:0]] <= bus.dm_wdata;
    assign bus.dm_rdata = mem[bus.dm_addr[7:0]];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_port(input bit p, input logic r, input logic w, input logic lk,
                            input logic [15:0] a, input logic [31:0] d);
        if (p) begin
            bus.req1 = r; bus.we1 = w; bus.lock1 = lk; bus.addr1 = a; bus.wdata1 = d;
        end else begin
            bus.req0 = r; bus.we0 = w; bus.lock0 = lk; bus.addr0 = a; bus.wdata0 = d;
        end
    endtask

    // Counts falling edges until any ack shows; a = {ack1, ack0}, zero on expiry.
    task automatic wait_any(output int n, output logic [1:0] a);
        n = 0;
        a = 2'b00;
        while (a == 2'b00 && n < 40) begin
            @(negedge clk);
            n++;
            a = {bus.ack1, bus.ack0};
        end
    endtask

    int         n;
    logic [1:0] a;
    logic [1:0] seen;

    initial begin
        set_port(0, 0, 0, 0, 16'h0, 32'h0);
        set_port(1, 0, 0, 0, 16'h0, 32'h0);
        repeat (2) @(negedge clk);
        chk("rst_ack", 32'({bus.ack1, bus.ack0}), 32'h0);
        chk("rst_we", 32'(bus.dm_we), 32'h0);
        chk("rst_addr", 32'(bus.dm_addr), 32'h0);
        chk("rst_wdata", bus.dm_wdata, 32'h0);
        chk("rst_rdata", bus.rdata, 32'h0);
        chk("rst_owner", 32'(bus.owner), 32'h0);
        rst_f = 1'b1;
        @(negedge clk);

        // Reset lands while a write is in ACCESS
        set_port(0, 1, 1, 0, 16'h0010, 32'hDEADBEEF);
        @(negedge clk);
        chk("mw_we_hi", 32'(bus.dm_we), 32'h1);
        chk("mw_addr", 32'(bus.dm_addr), 32'h10);
        rst_f = 1'b0;
        #1;
        chk("mw_we_drop", 32'(bus.dm_we), 32'h0);
        chk("mw_addr_rst", 32'(bus.dm_addr), 32'h0);
        chk("mw_wdata_rst", bus.dm_wdata, 32'h0);
        chk("mw_owner_rst", 32'(bus.owner), 32'h0);
        set_port(0, 0, 0, 0, 16'h0, 32'h0);
        @(negedge clk);
        chk("mw_mem", mem[16], 32'h0);
        chk("mw_ack", 32'({bus.ack1, bus.ack0}), 32'h0);
        rst_f = 1'b1;
        @(negedge clk);

        // Write then read back on port 0
        set_port(0, 1, 1, 0, 16'h0004, 32'h12345678);
        wait_any(n, a);
        chk("wr_ack", 32'(a), 32'h1);
        chk("wr_lat", 32'(n), 32'd2);
        set_port(0, 1, 0, 0, 16'h0004, 32'h0);
        wait_any(n, a);
        chk("rd_ack", 32'(a), 32'h1);
        chk("rd_lat", 32'(n), 32'd3);
        chk("rd_data", bus.rdata, 32'h12345678);
        set_port(0, 0, 0, 0, 16'h0, 32'h0);
        @(negedge clk);

        // Seed addresses 1 and 2, leaving the pointer on port 0
        set_port(0, 1, 1, 0, 16'h0001, 32'h000000A1);
        wait_any(n, a);
        chk("seed1_ack", 32'(a), 32'h1);
        set_port(0, 0, 0, 0, 16'h0, 32'h0);
        set_port(1, 1, 1, 0, 16'h0002, 32'h000000B2);
        wait_any(n, a);
        chk("seed2_ack", 32'(a), 32'h2);
        chk("seed2_lat", 32'(n), 32'd3);
        set_port(1, 0, 0, 0, 16'h0, 32'h0);
        @(negedge clk);

        // Both ports hold read requests: grants alternate 0,1,...
        set_port(0, 1, 0, 0, 16'h0001, 32'h0);
        set_port(1, 1, 0, 0, 16'h0002, 32'h0);
        for (int k = 0; k < 8; k++) begin
            wait_any(n, a);
            chk($sformatf("rr_ack%0d", k), 32'(a), (k % 2 == 0) ? 32'h1 : 32'h2);
            chk($sformatf("rr_lat%0d", k), 32'(n), (k == 0) ? 32'd2 : 32'd3);
            chk($sformatf("rr_data%0d", k), bus.rdata, (k % 2 == 0) ? 32'hA1 : 32'hB2);
        end
        set_port(0, 0, 0, 0, 16'h0, 32'h0);
        set_port(1, 0, 0, 0, 16'h0, 32'h0);
        @(negedge clk);

        // Atomic increment on port 1 while port 0 keeps requesting
        set_port(0, 1, 1, 0, 16'h0020, 32'h00000041);
        wait_any(n, a);
        chk("rmw_seed", 32'(a), 32'h1);
        set_port(0, 0, 0, 0, 16'h0, 32'h0);
        @(negedge clk);
        set_port(0, 1, 0, 0, 16'h0005, 32'h0);
        set_port(1, 1, 0, 1, 16'h0020, 32'h0);
        wait_any(n, a);
        chk("rmw_rd_ack", 32'(a), 32'h2);
        chk("rmw_rd_data", bus.rdata, 32'h41);
        chk("rmw_owner", 32'(bus.owner), 32'h2);
        set_port(1, 1, 1, 0, 16'h0020, 32'h00000042);
        wait_any(n, a);
        chk("rmw_wr_ack", 32'(a), 32'h2);
        chk("rmw_wr_lat", 32'(n), 32'd3);
        set_port(1, 0, 0, 0, 16'h0, 32'h0);
        wait_any(n, a);
        chk("rmw_p0_ack", 32'(a), 32'h1);
        chk("rmw_p0_lat", 32'(n), 32'd3);
        chk("rmw_p0_owner", 32'(bus.owner), 32'h1);
        chk("rmw_mem", mem[32], 32'h42);
        set_port(0, 0, 0, 0, 16'h0, 32'h0);
        @(negedge clk);

        // Port 0 locks then idles; port 1 gets in after the timeout
        set_port(0, 1, 0, 1, 16'h0000, 32'h0);
        wait_any(n, a);
        chk("tmo_lk_ack", 32'(a), 32'h1);
        chk("tmo_lk_owner", 32'(bus.owner), 32'h1);
        set_port(0, 0, 0, 0, 16'h0, 32'h0);
        set_port(1, 1, 0, 0, 16'h0002, 32'h0);
        wait_any(n, a);
        chk("tmo_ack", 32'(a), 32'h2);
        chk("tmo_lat", 32'(n), 32'd18);
        chk("tmo_owner", 32'(bus.owner), 32'h2);
        chk("tmo_data", bus.rdata, 32'hB2);
        set_port(1, 0, 0, 0, 16'h0, 32'h0);
        @(negedge clk);

        // Owner returns exactly on the expiry cycle and keeps priority
        set_port(0, 1, 0, 1, 16'h0001, 32'h0);
        wait_any(n, a);
        chk("sim_lk_ack", 32'(a), 32'h1);
        set_port(0, 0, 0, 0, 16'h0, 32'h0);
        set_port(1, 1, 0, 0, 16'h0002, 32'h0);
        seen = 2'b00;
        repeat (15) begin
            @(negedge clk);
            seen = seen | {bus.ack1, bus.ack0};
        end
        chk("sim_quiet", 32'(seen), 32'h0);
        set_port(0, 1, 0, 0, 16'h0001, 32'h0);
        wait_any(n, a);
        chk("sim_own_ack", 32'(a), 32'h1);
        chk("sim_own_lat", 32'(n), 32'd2);
        chk("sim_own_data", bus.rdata, 32'hA1);
        set_port(0, 0, 0, 0, 16'h0, 32'h0);
        wait_any(n, a);
        chk("sim_p1_ack", 32'(a), 32'h2);
        chk("sim_p1_lat", 32'(n), 32'd3);
        set_port(1, 0, 0, 0, 16'h0, 32'h0);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
